vga_sync_gen: RTL and testbench

Generates the 640x480 @ 60 Hz VGA raster timing for the calculator display: horizontal/vertical sync, the `bright` visible-area qualifier, and the `hCount`/`vCount` raster position consumed by the calculator output renderer. A 100 MHz system clock is divided down to a 25 MHz pixel-enable strobe; all counters advance on that strobe. The block is the producer end of the raster interface. The renderer maps `hCount`/`vCount` directly to pixels and colours a pixel only when `bright` is high.

---
 rtl/vga_timing_pkg.sv | 16 +
 rtl/vga_sync_gen_pix_en_div.sv | 33 +++
 rtl/vga_sync_gen.sv | 104 ++++++++++
 tb/tb_vga_sync_gen.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480 @ 60 Hz raster timing constants used by the sync generator and the renderer.
package vga_timing_pkg;

  localparam int COUNT_W = 10;

  localparam int H_TOTAL     = 800;
  localparam int H_SYNC      = 96;
  localparam int H_VIS_START = 144;
  localparam int H_VIS_END   = 784;

  localparam int V_TOTAL     = 525;
  localparam int V_SYNC      = 2;
  localparam int V_VIS_START = 35;
  localparam int V_VIS_END   = 515;

endpackage

// File: rtl/vga_sync_gen_pix_en_div.sv
// Pixel clock-enable divider: pix_en is high one clk in every CLK_DIV, starting from div_cnt=0 after reset.
module pix_en_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic pix_en
);

  generate
    if (CLK_DIV <= 1) begin : g_passthru
      assign pix_en = 1'b1;
    end else begin : g_div
      localparam int DIV_W = $clog2(CLK_DIV);
      localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

      logic [DIV_W-1:0] div_cnt;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end

      assign pix_en = (div_cnt == DIV_LAST);
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: counts, syncs, visible window, frame_start and blink.
// Optional macro VGA_SYNC_GEN_BLINK_EN builds the frame counter that drives blink; otherwise blink is 0.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int H_TOTAL      = vga_timing_pkg::H_TOTAL,
  parameter int H_SYNC       = vga_timing_pkg::H_SYNC,
  parameter int H_VIS_START  = vga_timing_pkg::H_VIS_START,
  parameter int H_VIS_END    = vga_timing_pkg::H_VIS_END,
  parameter int V_TOTAL      = vga_timing_pkg::V_TOTAL,
  parameter int V_SYNC       = vga_timing_pkg::V_SYNC,
  parameter int V_VIS_START  = vga_timing_pkg::V_VIS_START,
  parameter int V_VIS_END    = vga_timing_pkg::V_VIS_END,
  parameter int BLINK_FRAMES = 32
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pix_en,
  output logic [COUNT_W-1:0] hCount,
  output logic [COUNT_W-1:0] vCount,
  output logic               hSync,
  output logic               vSync,
  output logic               bright,
  output logic               frame_start,
  output logic               blink
);

  localparam logic [COUNT_W-1:0] H_LAST    = COUNT_W'(H_TOTAL - 1);
  localparam logic [COUNT_W-1:0] V_LAST    = COUNT_W'(V_TOTAL - 1);
  localparam logic [COUNT_W-1:0] H_SYNC_C  = COUNT_W'(H_SYNC);
  localparam logic [COUNT_W-1:0] V_SYNC_C  = COUNT_W'(V_SYNC);
  localparam logic [COUNT_W-1:0] H_VIS_S_C = COUNT_W'(H_VIS_START);
  localparam logic [COUNT_W-1:0] H_VIS_E_C = COUNT_W'(H_VIS_END);
  localparam logic [COUNT_W-1:0] V_VIS_S_C = COUNT_W'(V_VIS_START);
  localparam logic [COUNT_W-1:0] V_VIS_E_C = COUNT_W'(V_VIS_END);

  logic line_end;
  logic frame_end;
  logic frame_wrap_d;

  pix_en_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk    (clk),
    .reset  (reset),
    .pix_en (pix_en)
  );

  assign line_end  = pix_en && (hCount == H_LAST);
  assign frame_end = line_end && (vCount == V_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hCount <= '0;
      vCount <= '0;
    end else if (pix_en) begin
      if (hCount == H_LAST) begin
        hCount <= '0;
        vCount <= (vCount == V_LAST) ? '0 : vCount + 1'b1;
      end else begin
        hCount <= hCount + 1'b1;
      end
    end
  end

  // Pulse lands one clk after the wrap edge, so it marks the first (0,0) cycle's successor.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_wrap_d <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      frame_wrap_d <= frame_end;
      frame_start  <= frame_wrap_d;
    end
  end

  assign hSync  = ~(hCount < H_SYNC_C);
  assign vSync  = ~(vCount < V_SYNC_C);
  assign bright = (hCount >= H_VIS_S_C) && (hCount < H_VIS_E_C) &&
                  (vCount >= V_VIS_S_C) && (vCount < V_VIS_E_C);

`ifdef VGA_SYNC_GEN_BLINK_EN
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  logic [FRAME_W-1:0] frame_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      blink     <= 1'b0;
    end else if (frame_start) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt <= '0;
        blink     <= ~blink;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-width line config and a tiny-frame blink config, each compared
// every clk against a model that derives the raster state from clocks elapsed since reset release.
`timescale 1ns/1ps
module tb_vga_sync_gen;

  typedef struct packed {
    int clk_div;
    int h_total;
    int h_sync;
    int h_vis_start;
    int h_vis_end;
    int v_total;
    int v_sync;
    int v_vis_start;
    int v_vis_end;
    int blink_frames;
  } cfg_t;

  typedef struct packed {
    logic       pix_en;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       br;
    logic       fs;
    logic       bl;
  } obs_t;

  typedef struct {
    obs_t e;
    int   t;
  } item_t;

  localparam cfg_t CFG_A = '{4, 800, 96, 144, 784, 12, 2, 3, 10, 32};
  localparam cfg_t CFG_B = '{2, 20, 3, 5, 17, 10, 2, 3, 8, 32};
  localparam int FRAME_A = 4 * 800 * 12;
  localparam int FRAME_B = 2 * 20 * 10;

  logic clk;
  logic rst_a, rst_b;
  logic       pix_en_a, hs_a, vs_a, br_a, fs_a, bl_a;
  logic       pix_en_b, hs_b, vs_b, br_b, fs_b, bl_b;
  logic [9:0] h_a, v_a, h_b, v_b;

  int    checks = 0;
  int    errors = 0;
  int    t_a = 0;
  int    t_b = 0;
  item_t q_a[$];
  item_t q_b[$];

  vga_sync_gen #(
    .CLK_DIV(CFG_A.clk_div), .H_TOTAL(CFG_A.h_total), .H_SYNC(CFG_A.h_sync),
    .H_VIS_START(CFG_A.h_vis_start), .H_VIS_END(CFG_A.h_vis_end),
    .V_TOTAL(CFG_A.v_total), .V_SYNC(CFG_A.v_sync),
    .V_VIS_START(CFG_A.v_vis_start), .V_VIS_END(CFG_A.v_vis_end),
    .BLINK_FRAMES(CFG_A.blink_frames)
  ) dut_a (
    .clk(clk), .reset(rst_a), .pix_en(pix_en_a), .hCount(h_a), .vCount(v_a),
    .hSync(hs_a), .vSync(vs_a), .bright(br_a), .frame_start(fs_a), .blink(bl_a)
  );

  vga_sync_gen #(
    .CLK_DIV(CFG_B.clk_div), .H_TOTAL(CFG_B.h_total), .H_SYNC(CFG_B.h_sync),
    .H_VIS_START(CFG_B.h_vis_start), .H_VIS_END(CFG_B.h_vis_end),
    .V_TOTAL(CFG_B.v_total), .V_SYNC(CFG_B.v_sync),
    .V_VIS_START(CFG_B.v_vis_start), .V_VIS_END(CFG_B.v_vis_end),
    .BLINK_FRAMES(CFG_B.blink_frames)
  ) dut_b (
    .clk(clk), .reset(rst_b), .pix_en(pix_en_b), .hCount(h_b), .vCount(v_b),
    .hSync(hs_b), .vSync(vs_b), .bright(br_b), .frame_start(fs_b), .blink(bl_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // t is the number of clk edges since reset release; the whole raster follows from it.
  function automatic obs_t model(input cfg_t c, input int t);
    obs_t e;
    int p, h, v, fc;
    fc = c.clk_div * c.h_total * c.v_total;
    p  = t / c.clk_div;
    h  = p % c.h_total;
    v  = (p / c.h_total) % c.v_total;
    e.pix_en = ((t % c.clk_div) == (c.clk_div - 1));
    e.h  = 10'(h);
    e.v  = 10'(v);
    e.hs = (h >= c.h_sync);
    e.vs = (v >= c.v_sync);
    e.br = (h >= c.h_vis_start) && (h < c.h_vis_end) &&
           (v >= c.v_vis_start) && (v < c.v_vis_end);
    e.fs = (t >= fc) && ((t % fc) == 1);
`ifdef VGA_SYNC_GEN_BLINK_EN
    begin
      int k;
      k = (t >= 2) ? (t - 2) / fc : 0;
      e.bl = (((k / c.blink_frames) % 2) == 1);
    end
`else
    e.bl = 1'b0;
`endif
    return e;
  endfunction

  function automatic obs_t reset_obs(input cfg_t c);
    obs_t e;
    e = '0;
    e.pix_en = (c.clk_div == 1);
    return e;
  endfunction

  task automatic applyStimulus(input int id, input logic rst_val, input int n);
    item_t it;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (id == 0) begin
        if (!rst_a) t_a++;
        rst_a = rst_val;
        if (rst_a) t_a = 0;
        it.t = t_a;
        it.e = rst_a ? reset_obs(CFG_A) : model(CFG_A, t_a);
        q_a.push_back(it);
      end else begin
        if (!rst_b) t_b++;
        rst_b = rst_val;
        if (rst_b) t_b = 0;
        it.t = t_b;
        it.e = rst_b ? reset_obs(CFG_B) : model(CFG_B, t_b);
        q_b.push_back(it);
      end
    end
  endtask

  task automatic checkOutput(input string name, input int t, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s t=%0d got pix_en=%b h=%0d v=%0d hs=%b vs=%b br=%b fs=%b bl=%b required pix_en=%b h=%0d v=%0d hs=%b vs=%b br=%b fs=%b bl=%b",
               name, t, got.pix_en, got.h, got.v, got.hs, got.vs, got.br, got.fs, got.bl,
               exp.pix_en, exp.h, exp.v, exp.hs, exp.vs, exp.br, exp.fs, exp.bl);
    end
  endtask

  always @(negedge clk) begin
    item_t it;
    obs_t  g;
    if (q_a.size() > 0) begin
      it = q_a.pop_front();
      g  = {pix_en_a, h_a, v_a, hs_a, vs_a, br_a, fs_a, bl_a};
      checkOutput("dut_a", it.t, g, it.e);
    end
    if (q_b.size() > 0) begin
      it = q_b.pop_front();
      g  = {pix_en_b, h_b, v_b, hs_b, vs_b, br_b, fs_b, bl_b};
      checkOutput("dut_b", it.t, g, it.e);
    end
  end

  initial begin
    repeat (100000) @(posedge clk);
    $display("[TB] FAIL watchdog cycle budget expired got running required finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    fork
      begin
        // Reset mid-line at hCount=400, then a full frame past the wrap, then a random reset.
        applyStimulus(0, 1'b1, 3);
        applyStimulus(0, 1'b0, 1602);
        applyStimulus(0, 1'b1, $urandom_range(1, 4));
        applyStimulus(0, 1'b0, FRAME_A + 800);
        applyStimulus(0, 1'b1, $urandom_range(1, 3));
        applyStimulus(0, 1'b0, $urandom_range(500, 3500));
      end
      begin
        // Tiny frames: random early reset, then 64 frames to cover two blink toggles.
        applyStimulus(1, 1'b1, 3);
        applyStimulus(1, 1'b0, $urandom_range(50, 390));
        applyStimulus(1, 1'b1, $urandom_range(1, 3));
        applyStimulus(1, 1'b0, 64 * FRAME_B + 10);
      end
    join
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
